hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter NUM_RD, default 2: number of ID-stage register read ports.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter ADDR_W, default 5: register address width.
REQ-004 Parameter MDU_LAT, default 8: cycles a multiply/divide occupies HI/LO; legal range 1..255.
REQ-005 Port clk input 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_n input 1: asynchronous, active-low reset.
REQ-007 Ports id_raddr input NUM_RD*ADDR_W and id_rden input NUM_RD: ID read addresses (port i at bits [i*ADDR_W +: ADDR_W]) and their enables.
REQ-008 Port id_use_hilo input 1: ID instruction reads HI/LO.
REQ-009 Ports ex_reg_wr input 1, ex_is_load input 1, ex_waddr input ADDR_W, ex_result input DATA_W: EX-stage write info.
REQ-010 Ports mem_reg_wr input 1, mem_waddr input ADDR_W, mem_result input DATA_W: MEM-stage write info; mem_result is final data, including load data.
REQ-011 Ports wb_reg_wr input 1, wb_waddr input ADDR_W, wb_result input DATA_W: WB-stage write info.
REQ-012 Port mdu_issue input 1: a mul/div leaves EX this cycle.
REQ-013 Port flush input 1: a taken branch/exception kills the ID instruction.
REQ-014 Ports fwd_hit output NUM_RD and fwd_data output NUM_RD*DATA_W: per-port bypass select and bypass value.
REQ-015 Ports stall_id output 1 and bubble_ex output 1: hold PC and IF/ID; insert NOP into ID/EX.
REQ-016 Ports mdu_busy output 1 and stall_cnt output 32: HI/LO busy flag; saturating stall-cycle counter.

Function
REQ-017 For each port i, a source matches when its reg_wr is 1, its waddr equals id_raddr[i], id_rden[i] is 1, and id_raddr[i] is not 0.
REQ-018 Forward priority SHALL be EX > MEM > WB; fwd_data[i] is the highest-priority matching result; fwd_hit[i]=1 on any match.
REQ-019 If no source matches, fwd_hit[i]=0 and fwd_data[i]=0.
REQ-020 An EX match with ex_is_load=1 SHALL NOT forward; it raises load-use and lower-priority sources are not used for that port.
REQ-021 Load-use SHALL assert stall_id=1 and bubble_ex=1 combinationally in the same cycle. Next cycle the load is in MEM and the MEM forward resolves it, so the penalty is exactly 1 cycle.
REQ-022 MDU state machine states: IDLE and BUSY. IDLE->BUSY on mdu_issue, loading the down-counter with MDU_LAT-1. In BUSY the counter decrements each cycle; BUSY->IDLE when the counter is 0.
REQ-023 mdu_busy=1 exactly in the BUSY state.
REQ-024 mdu_issue while BUSY SHALL reload the counter with MDU_LAT-1 (back-to-back ops); the state stays BUSY.
REQ-025 id_use_hilo=1 while mdu_busy=1 SHALL assert stall_id=1 and bubble_ex=1.
REQ-026 flush=1 SHALL force stall_id=0 and bubble_ex=0 that cycle, regardless of hazards. flush SHALL NOT alter MDU state.
REQ-027 stall_cnt increments by 1 on each cycle with stall_id=1 and saturates at 0xFFFFFFFF.
REQ-028 Forwarding outputs are pure combinational functions of the current inputs; the only registered state is the MDU state, the MDU counter and stall_cnt.

Reset
REQ-029 On rst_n=0, asynchronously: MDU state=IDLE, counter=0, stall_cnt=0, mdu_busy=0.
REQ-030 Reset asserted during BUSY SHALL abandon the operation; mdu_busy reads 0 in the first cycle after release.
REQ-031 While reset is held, combinational outputs follow REQ-017..REQ-021 and REQ-026; stall_id from MDU is 0.

Structure
REQ-032 A shared package SHALL hold the MDU state enum, the default parameter values, and the constant REG_ZERO=0.
REQ-033 One sub-module fwd_mux SHALL hold the per-port priority select; it is instantiated NUM_RD times via generate.

Verification
REQ-034 EX and MEM both write r3; ID reads r3 on port 0 -> fwd_hit[0]=1, fwd_data[0]=ex_result (e.g. 0x11 over 0x22).
REQ-035 WB writes r0 with 0xDEAD; ID reads r0 -> fwd_hit=0, fwd_data=0.
REQ-036 EX load to r5; ID reads r5 on port 1 -> cycle N: stall_id=1, bubble_ex=1. Cycle N+1: MEM match, fwd_data[1]=mem_result, no stall; stall_cnt=1.
REQ-037 MDU_LAT=4: mdu_issue at cycle 0, then id_use_hilo held -> mdu_busy=1 and stall_id=1 for cycles 1..4, 0 at cycle 5. A reissue at cycle 2 extends the busy window to cycle 6.
REQ-038 Load-use plus flush in the same cycle -> stall_id=0, bubble_ex=0; stall_cnt unchanged.
REQ-039 rst_n pulsed low mid-BUSY -> mdu_busy=0 and stall_cnt=0 immediately; no stall after release.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types and defaults for the hazard unit: MDU state encoding,
// default parameter values and the hard-wired zero register index.
package hazard_unit_pkg;

    localparam int unsigned NUM_RD_DEF  = 2;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned MDU_LAT_DEF = 8;

    localparam int unsigned REG_ZERO = 0;

    // MDU latencies go up to 255, so the down-counter fits in 8 bits
    localparam int unsigned MDU_CNT_W = 8;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/hazard_unit_fwd_mux.sv
// Per-read-port bypass select: EX > MEM > WB priority.
// An EX match on a load blocks forwarding and flags load-use instead.
module fwd_mux
    import hazard_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic              rden,
    input  logic              ex_reg_wr,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_reg_wr,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_wr,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_result,
    output logic              hit,
    output logic [DATA_W-1:0] data,
    output logic              load_use
);

    logic valid;

    always_comb begin
        hit      = 1'b0;
        data     = '0;
        load_use = 1'b0;
        valid    = rden && (raddr != ADDR_W'(REG_ZERO));
        if (valid) begin
            if (ex_reg_wr && (ex_waddr == raddr)) begin
                if (ex_is_load) begin
                    load_use = 1'b1;
                end else begin
                    hit  = 1'b1;
                    data = ex_result;
                end
            end else if (mem_reg_wr && (mem_waddr == raddr)) begin
                hit  = 1'b1;
                data = mem_result;
            end else if (wb_reg_wr && (wb_waddr == raddr)) begin
                hit  = 1'b1;
                data = wb_result;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand bypass selection, load-use and HI/LO
// interlocks, MDU busy tracking and a saturating stall-cycle counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned NUM_RD  = NUM_RD_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned MDU_LAT = MDU_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] id_raddr,
    input  logic [NUM_RD-1:0]        id_rden,
    input  logic                     id_use_hilo,
    input  logic                     ex_reg_wr,
    input  logic                     ex_is_load,
    input  logic [ADDR_W-1:0]        ex_waddr,
    input  logic [DATA_W-1:0]        ex_result,
    input  logic                     mem_reg_wr,
    input  logic [ADDR_W-1:0]        mem_waddr,
    input  logic [DATA_W-1:0]        mem_result,
    input  logic                     wb_reg_wr,
    input  logic [ADDR_W-1:0]        wb_waddr,
    input  logic [DATA_W-1:0]        wb_result,
    input  logic                     mdu_issue,
    input  logic                     flush,
    output logic [NUM_RD-1:0]        fwd_hit,
    output logic [NUM_RD*DATA_W-1:0] fwd_data,
    output logic                     stall_id,
    output logic                     bubble_ex,
    output logic                     mdu_busy,
    output logic [31:0]              stall_cnt
);

    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LAT - 1);

    logic [NUM_RD-1:0]    load_use;
    logic                 hazard;
    mdu_state_e           state;
    logic [MDU_CNT_W-1:0] cnt;

    for (genvar g = 0; g < NUM_RD; g++) begin : gen_port
        fwd_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_fwd_mux (
            .raddr      (id_raddr[g*ADDR_W +: ADDR_W]),
            .rden       (id_rden[g]),
            .ex_reg_wr  (ex_reg_wr),
            .ex_is_load (ex_is_load),
            .ex_waddr   (ex_waddr),
            .ex_result  (ex_result),
            .mem_reg_wr (mem_reg_wr),
            .mem_waddr  (mem_waddr),
            .mem_result (mem_result),
            .wb_reg_wr  (wb_reg_wr),
            .wb_waddr   (wb_waddr),
            .wb_result  (wb_result),
            .hit        (fwd_hit[g]),
            .data       (fwd_data[g*DATA_W +: DATA_W]),
            .load_use   (load_use[g])
        );
    end

    // A flush kills the ID instruction, so any hazard it had is moot
    assign hazard    = (|load_use) || (id_use_hilo && mdu_busy);
    assign stall_id  = hazard && !flush;
    assign bubble_ex = stall_id;

    // MDU occupancy: reissue while busy restarts the full latency window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MDU_IDLE;
            cnt      <= '0;
            mdu_busy <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (mdu_issue) begin
                        state    <= MDU_BUSY;
                        cnt      <= CNT_LOAD;
                        mdu_busy <= 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_issue) begin
                        cnt <= CNT_LOAD;
                    end else if (cnt == '0) begin
                        state    <= MDU_IDLE;
                        mdu_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - MDU_CNT_W'(1);
                    end
                end
                default: begin
                    state    <= MDU_IDLE;
                    cnt      <= '0;
                    mdu_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_id && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: per-cycle reference model compare
// plus hand-computed directed expectations.
module tb_hazard_unit;

    localparam int unsigned NRD = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 4;

    logic              clk;
    logic              rst_n;
    logic [NRD*AW-1:0] id_raddr;
    logic [NRD-1:0]    id_rden;
    logic              id_use_hilo;
    logic              ex_reg_wr, ex_is_load;
    logic [AW-1:0]     ex_waddr;
    logic [DW-1:0]     ex_result;
    logic              mem_reg_wr;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_result;
    logic              wb_reg_wr;
    logic [AW-1:0]     wb_waddr;
    logic [DW-1:0]     wb_result;
    logic              mdu_issue, flush;
    logic [NRD-1:0]    fwd_hit;
    logic [NRD*DW-1:0] fwd_data;
    logic              stall_id, bubble_ex, mdu_busy;
    logic [31:0]       stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // model state: busy cycles still to come, and stall cycles seen
    int          m_rem = 0;
    logic [31:0] m_cnt = '0;

    hazard_unit #(
        .NUM_RD  (NRD),
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .MDU_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_raddr    (id_raddr),
        .id_rden     (id_rden),
        .id_use_hilo (id_use_hilo),
        .ex_reg_wr   (ex_reg_wr),
        .ex_is_load  (ex_is_load),
        .ex_waddr    (ex_waddr),
        .ex_result   (ex_result),
        .mem_reg_wr  (mem_reg_wr),
        .mem_waddr   (mem_waddr),
        .mem_result  (mem_result),
        .wb_reg_wr   (wb_reg_wr),
        .wb_waddr    (wb_waddr),
        .wb_result   (wb_result),
        .mdu_issue   (mdu_issue),
        .flush       (flush),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .stall_id    (stall_id),
        .bubble_ex   (bubble_ex),
        .mdu_busy    (mdu_busy),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scan sources youngest-first; the first writer of the register decides
    function automatic void model_port(input int p, output logic hit,
                                       output logic [DW-1:0] data, output logic lu);
        logic          wr[3];
        logic [AW-1:0] wa[3];
        logic [DW-1:0] rs[3];
        logic [AW-1:0] a;
        wr = '{ex_reg_wr, mem_reg_wr, wb_reg_wr};
        wa = '{ex_waddr, mem_waddr, wb_waddr};
        rs = '{ex_result, mem_result, wb_result};
        a    = id_raddr[p*AW +: AW];
        hit  = 1'b0;
        data = '0;
        lu   = 1'b0;
        if (!id_rden[p] || a == '0) return;
        for (int k = 0; k < 3; k++) begin
            if (wr[k] && wa[k] == a) begin
                if (k == 0 && ex_is_load) lu = 1'b1;
                else begin
                    hit  = 1'b1;
                    data = rs[k];
                end
                return;
            end
        end
    endfunction

    function automatic logic model_stall();
        logic h, lu, any_lu;
        logic [DW-1:0] d;
        any_lu = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            model_port(p, h, d, lu);
            any_lu = any_lu | lu;
        end
        return !flush && (any_lu || (id_use_hilo && m_rem > 0));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem <= 0;
            m_cnt <= '0;
        end else begin
            if (mdu_issue) m_rem <= LAT;
            else if (m_rem > 0) m_rem <= m_rem - 1;
            if (model_stall() && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        logic [NRD-1:0]    e_hit;
        logic [NRD*DW-1:0] e_data;
        logic              h, lu, st;
        logic [DW-1:0]     d;
        for (int p = 0; p < NRD; p++) begin
            model_port(p, h, d, lu);
            e_hit[p]            = h;
            e_data[p*DW +: DW]  = d;
        end
        st = model_stall();
        check("m_fwd_hit", 64'(fwd_hit), 64'(e_hit));
        check("m_fwd_data", 64'(fwd_data), 64'(e_data));
        check("m_stall_id", 64'(stall_id), 64'(st));
        check("m_bubble_ex", 64'(bubble_ex), 64'(st));
        check("m_mdu_busy", 64'(mdu_busy), 64'(m_rem > 0));
        check("m_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    end

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_raddr = '0; id_rden = '0; id_use_hilo = 1'b0;
        ex_reg_wr = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; ex_result = '0;
        mem_reg_wr = 1'b0; mem_waddr = '0; mem_result = '0;
        wb_reg_wr = 1'b0; wb_waddr = '0; wb_result = '0;
        mdu_issue = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #1 rst_n = 1'b0;

        // load-use is still visible while held in reset
        ex_reg_wr = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd7;
        id_raddr = {5'd0, 5'd7}; id_rden = 2'b01;
        settle();
        check("rst_stall", 64'(stall_id), 64'd1);
        check("rst_busy", 64'(mdu_busy), 64'd0);
        check("rst_cnt", 64'(stall_cnt), 64'd0);
        adv();
        idle_inputs();
        rst_n = 1'b1;

        // EX beats MEM on the same register
        ex_reg_wr = 1'b1; ex_waddr = 5'd3; ex_result = 32'h11;
        mem_reg_wr = 1'b1; mem_waddr = 5'd3; mem_result = 32'h22;
        id_raddr = {5'd0, 5'd3}; id_rden = 2'b01;
        settle();
        check("ex_prio_hit", 64'(fwd_hit[0]), 64'd1);
        check("ex_prio_data", 64'(fwd_data[31:0]), 64'h11);
        adv();
        idle_inputs();

        // r0 never forwards
        wb_reg_wr = 1'b1; wb_waddr = 5'd0; wb_result = 32'hDEAD;
        id_raddr = '0; id_rden = 2'b11;
        settle();
        check("r0_hit", 64'(fwd_hit), 64'd0);
        check("r0_data", 64'(fwd_data), 64'd0);
        adv();
        idle_inputs();

        // load-use: one stall, then resolved from MEM
        ex_reg_wr = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5;
        id_raddr = {5'd5, 5'd0}; id_rden = 2'b10;
        settle();
        check("lu_stall", 64'(stall_id), 64'd1);
        check("lu_bubble", 64'(bubble_ex), 64'd1);
        adv();
        ex_reg_wr = 1'b0; ex_is_load = 1'b0;
        mem_reg_wr = 1'b1; mem_waddr = 5'd5; mem_result = 32'hCAFE;
        settle();
        check("lu_mem_hit", 64'(fwd_hit[1]), 64'd1);
        check("lu_mem_data", 64'(fwd_data[63:32]), 64'hCAFE);
        check("lu_nostall", 64'(stall_id), 64'd0);
        check("lu_cnt", 64'(stall_cnt), 64'd1);
        adv();
        idle_inputs();

        // MDU window, latency 4
        mdu_issue = 1'b1; id_use_hilo = 1'b1;
        settle();
        check("mdu_c0_busy", 64'(mdu_busy), 64'd0);
        adv();
        mdu_issue = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            check("mdu_busy_win", 64'(mdu_busy), 64'd1);
            check("mdu_stall_win", 64'(stall_id), 64'd1);
            adv();
        end
        settle();
        check("mdu_c5_busy", 64'(mdu_busy), 64'd0);
        check("mdu_c5_stall", 64'(stall_id), 64'd0);
        check("mdu_c5_cnt", 64'(stall_cnt), 64'd5);
        adv();

        // reissue at cycle 2 stretches busy to cycle 6
        mdu_issue = 1'b1;
        settle();
        adv();
        for (int c = 1; c <= 6; c++) begin
            mdu_issue = (c == 2);
            settle();
            check("reissue_busy", 64'(mdu_busy), 64'd1);
            adv();
        end
        mdu_issue = 1'b0;
        settle();
        check("reissue_c7_busy", 64'(mdu_busy), 64'd0);
        check("reissue_cnt", 64'(stall_cnt), 64'd11);
        adv();
        idle_inputs();

        // flush overrides load-use and does not count
        ex_reg_wr = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5;
        id_raddr = {5'd5, 5'd0}; id_rden = 2'b10; flush = 1'b1;
        settle();
        check("flush_stall", 64'(stall_id), 64'd0);
        check("flush_bubble", 64'(bubble_ex), 64'd0);
        adv();
        idle_inputs();
        settle();
        check("flush_cnt", 64'(stall_cnt), 64'd11);
        adv();

        // directed forwarding vectors, checked by the model compare
        for (int i = 0; i < 16; i++) begin
            ex_reg_wr  = i[0];
            mem_reg_wr = i[1] | i[3];
            wb_reg_wr  = i[2] | i[0];
            ex_is_load = (i % 5 == 0);
            ex_waddr   = AW'(i % 4);
            mem_waddr  = AW'((i / 2) % 4);
            wb_waddr   = AW'((i / 3) % 4);
            ex_result  = 32'h100 + 32'(i);
            mem_result = 32'h200 + 32'(i);
            wb_result  = 32'h300 + 32'(i);
            id_raddr   = {AW'((i + 1) % 4), AW'(i % 4)};
            id_rden    = (i == 6) ? 2'b00 : 2'b11;
            flush      = (i == 7);
            mdu_issue  = (i == 9);
            id_use_hilo = (i >= 10);
            settle();
            adv();
        end
        idle_inputs();
        mdu_issue = 1'b1;
        adv();
        mdu_issue = 1'b0;
        id_use_hilo = 1'b1;

        // reset mid-BUSY abandons the operation
        settle();
        check("pre_rst_busy", 64'(mdu_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 64'(mdu_busy), 64'd0);
        check("async_cnt", 64'(stall_cnt), 64'd0);
        adv();
        rst_n = 1'b1;
        settle();
        check("post_rst_busy", 64'(mdu_busy), 64'd0);
        check("post_rst_stall", 64'(stall_id), 64'd0);
        adv();
        idle_inputs();
        settle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
